// File: rtl/alu_mc_if.sv
// ---------------------------------------------------------------------------
// Module   : alu_mc_if
// Brief    : Operand/opcode request and result/flag bus for the alu_mc unit.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_mc_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] accum;
  logic [WIDTH-1:0] alu_in;
  logic [3:0]       alu_sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             z;
  logic             c;

  modport master (
    output start, accum, alu_in, alu_sel,
    input  busy, done, result, z, c
  );

  modport slave (
    input  start, accum, alu_in, alu_sel,
    output busy, done, result, z, c
  );
endinterface

`default_nettype wire

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// Module   : alu_mc
// Brief    : Multi-cycle ALU, registered result/flags, iterative shift-add MUL.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_mc #(
  parameter int WIDTH = 8
) (
  input  wire logic clk,
  input  wire logic rst,
  alu_mc_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] c_op_add  = 4'b0001;
  localparam logic [3:0] c_op_sub  = 4'b0010;
  localparam logic [3:0] c_op_nor  = 4'b0011;
  localparam logic [3:0] c_op_movr = 4'b0100;
  localparam logic [3:0] c_op_mul  = 4'b0101;
  localparam logic [3:0] c_op_shl  = 4'b1011;
  localparam logic [3:0] c_op_shr  = 4'b1100;

  localparam logic [0:0] c_st_idle    = 1'b0;
  localparam logic [0:0] c_st_mul_run = 1'b1;

  logic [0:0]         r_state;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic               r_z;
  logic               r_c;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_cout;
  logic               w_legal;
  logic               w_accept;
  logic [2*WIDTH-1:0] w_prod_next;

  always_comb begin
    w_sum   = {1'b0, bus.accum} + {1'b0, bus.alu_in};
    w_diff  = {1'b0, bus.accum} - {1'b0, bus.alu_in};
    w_res   = r_result;
    w_cout  = r_c;
    w_legal = 1'b1;
    case (bus.alu_sel)
      c_op_add:  begin w_res = w_sum[WIDTH-1:0];  w_cout = w_sum[WIDTH];  end
      // Top bit of the widened difference is the borrow (A < B unsigned).
      c_op_sub:  begin w_res = w_diff[WIDTH-1:0]; w_cout = w_diff[WIDTH]; end
      c_op_nor:  begin w_res = ~(bus.accum | bus.alu_in); w_cout = 1'b0; end
      c_op_movr: begin w_res = bus.alu_in; w_cout = 1'b0; end
      c_op_shl:  begin w_res = {bus.accum[WIDTH-2:0], 1'b0}; w_cout = bus.accum[WIDTH-1]; end
      c_op_shr:  begin w_res = {1'b0, bus.accum[WIDTH-1:1]}; w_cout = bus.accum[0]; end
      default:   w_legal = 1'b0;
    endcase
  end

  assign w_accept    = bus.start && (r_state == c_st_idle);
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_st_idle;
      r_done   <= 1'b0;
      r_result <= '0;
      r_z      <= 1'b1;
      r_c      <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            if (bus.alu_sel == c_op_mul) begin
              r_mcand  <= {{WIDTH{1'b0}}, bus.accum};
              r_mplier <= bus.alu_in;
              r_prod   <= '0;
              r_cnt    <= CW'(WIDTH);
              r_state  <= c_st_mul_run;
            end else begin
              // Illegal opcodes still complete so the control unit never stalls.
              r_done <= 1'b1;
              if (w_legal) begin
                r_result <= w_res;
                r_z      <= (w_res == '0);
                r_c      <= w_cout;
              end
            end
          end
        end
        c_st_mul_run: begin
          r_prod   <= w_prod_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_result <= w_prod_next[WIDTH-1:0];
            r_z      <= (w_prod_next[WIDTH-1:0] == '0);
            r_c      <= |w_prod_next[2*WIDTH-1:WIDTH];
            r_done   <= 1'b1;
            r_state  <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.busy   = (r_state == c_st_mul_run);
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.z      = r_z;
  assign bus.c      = r_c;

endmodule

`default_nettype wire
